// File: rtl/result_reader.sv
// Result BRAM readback: fetches PE_COUNT-lane vector words one at a time and
// serializes them, lane 0 first, onto a valid/ready stream.
module result_reader #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            length,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] rd_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done
);
    localparam int LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] STREAM  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH+1)'(BRAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [LANE_W-1:0]     LANE_MAX  = LANE_W'(PE_COUNT - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] lane_buf [PE_COUNT];
    logic                  zero_wait;
    logic                  last_lane;

    assign last_lane = (lane == LANE_MAX);
    assign rd_en     = (state == ISSUE);
    assign rd_addr   = rd_addr_q;
    assign m_valid   = (state == STREAM);
    assign m_data    = lane_buf[lane];
    assign m_last    = m_valid && last_lane && (word_cnt == '0);
    assign busy      = (state != IDLE);
    // A zero-length request spends one extra cycle in DONE so the pulse lands two cycles after start.
    assign done      = (state == DONE) && !zero_wait;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            rd_addr_q <= '0;
            word_cnt  <= '0;
            lane      <= '0;
            zero_wait <= 1'b0;
            for (int i = 0; i < PE_COUNT; i++) lane_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt  <= base_addr;
                        word_cnt  <= (length > DEPTH_LEN) ? DEPTH_LEN : length;
                        zero_wait <= (length == '0);
                        if (length == '0) begin
                            state <= DONE;
                        end else begin
                            rd_addr_q <= base_addr;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    for (int i = 0; i < PE_COUNT; i++)
                        lane_buf[i] <= rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    lane     <= '0;
                    addr_cnt <= (addr_cnt == ADDR_MAX) ? '0 : addr_cnt + ADDR_WIDTH'(1);
                    word_cnt <= word_cnt - (ADDR_WIDTH+1)'(1);
                    state    <= STREAM;
                end
                STREAM: begin
                    if (m_ready) begin
                        if (!last_lane) begin
                            lane <= lane + LANE_W'(1);
                        end else if (word_cnt != '0) begin
                            // addr_cnt already points at the next word after CAPTURE.
                            rd_addr_q <= addr_cnt;
                            state     <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (zero_wait) zero_wait <= 1'b0;
                    else           state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_reader.sv
// Randomized readback checks for result_reader against a queue-based model of
// the expected address sequence and beat stream.
module tb_result_reader;
    localparam int PE    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PE*DW-1:0] rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [PE*DW-1:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;

    result_reader dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, garbage when not enabled.
    always @(posedge clk)
        rd_data <= rd_en ? mem[rd_addr] : {$urandom, $urandom, $urandom, $urandom};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"},   rd_en,   1'b0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_data"},  m_data,  0);
        chk({tag, "_m_last"},  m_last,  1'b0);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_done"},    done,    1'b0);
    endtask

    // One readback from start to done; k counts cycles after the start-sampling edge.
    task automatic run(input int base, input int len, input int stall_pct, input bit poke);
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        int            exp_a[$];
        int words, budget, addr;
        int first_rd, first_v, done_at, last_hs, ndone, nbusy, nbeats, nrd, hits100;
        logic [DW-1:0] pd;
        logic          pl;
        bit            stalled, poked;
        words = (len > DEPTH) ? DEPTH : len;
        for (int w = 0; w < words; w++) begin
            addr = (base + w) % DEPTH;
            exp_a.push_back(addr);
            for (int l = 0; l < PE; l++) begin
                exp_d.push_back(mem[addr][l*DW +: DW]);
                exp_l.push_back(w == words - 1 && l == PE - 1);
            end
        end
        first_rd = -1; first_v = -1; done_at = -1; last_hs = -1;
        ndone = 0; nbusy = 0; nbeats = 0; nrd = 0; hits100 = 0;
        stalled = 0; poked = 0; pd = '0; pl = 1'b0;
        budget = 20 + words * (PE + 2) * 10;

        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = 1'b0;
            m_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (busy) nbusy++;
            if (rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = k;
                if (rd_addr == 100) hits100++;
                if (exp_a.size() > 0) chk("rd_addr", rd_addr, exp_a.pop_front());
            end
            if (stalled) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, pd);
                chk("stall_last", m_last, pl);
            end
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                if (m_ready) begin
                    nbeats++;
                    last_hs = k;
                    if (exp_d.size() > 0) begin
                        chk("beat_data", m_data, exp_d.pop_front());
                        chk("beat_last", m_last, exp_l.pop_front());
                    end
                end
                if (poke && !poked) begin
                    start = 1'b1; base_addr = 100; length = 5; poked = 1;
                end
            end
            stalled = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0) break;
        end
        chk("done_seen", done_at > 0, 1'b1);
        chk("beat_count", nbeats, words * PE);
        chk("rd_count", nrd, words);
        chk("done_pulses", ndone, 1);
        if (poke) chk("poke_addr100", hits100, 0);
        if (words > 0) begin
            chk("first_rd_en", first_rd, 1);
            chk("first_valid", first_v, 3);
            chk("done_after_last", done_at, last_hs + 1);
            if (stall_pct == 0) chk("word_rate", done_at, words * (PE + 2) + 1);
        end else begin
            chk("zero_done_at", done_at, 2);
            chk("zero_busy", nbusy, 2);
            chk("zero_valid", first_v, -1);
            chk("zero_rd", first_rd, -1);
        end
        @(negedge clk);
        #1;
        chk("after_busy", busy, 1'b0);
        chk("after_valid", m_valid, 1'b0);
        chk("after_done", done, 1'b0);
    endtask

    initial begin
        int nb;
        for (int k = 0; k < DEPTH; k++)
            for (int l = 0; l < PE; l++)
                mem[k][l*DW +: DW] = DW'(k * 16 + l);

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;

        run(5, 2, 0, 0);          // beats 80..83, 96..99
        run(1023, 3, 0, 0);       // address wrap 1023, 0, 1
        run(7, 0, 0, 0);          // zero length
        run(40, 1, 50, 0);        // stalling consumer
        run(1020, 2000, 0, 0);    // clamped to full depth
        run(200, 3, 30, 1);       // start re-pulsed while streaming

        // Abort a length-4 readback after its second beat.
        @(negedge clk);
        start = 1'b1; base_addr = 10; length = 4; m_ready = 1'b1;
        nb = 0;
        for (int k = 0; k < 50 && nb < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) nb++;
        end
        chk("abort_beats", nb, 2);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk_idle_outputs("abort");
        run(0, 1, 0, 0);

        for (int k = 0; k < DEPTH; k++)
            mem[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 0; r < 8; r++)
            run($urandom_range(DEPTH - 1), $urandom_range(6), $urandom_range(60), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter PE_COUNT, default 4: number of 32-bit lanes per BRAM vector word.
REQ-002 Parameter DATA_WIDTH, default 32: lane width in bits.
REQ-003 Parameter BRAM_DEPTH, default 1024: vector words in the result BRAM.
REQ-004 Parameter ADDR_WIDTH, default $clog2(BRAM_DEPTH): BRAM address width.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a readback; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_WIDTH  first vector word to read; sampled with start.
REQ-009 length  input  ADDR_WIDTH+1  number of vector words to read; sampled with start.
REQ-010 rd_en  output  1  BRAM read port enable.
REQ-011 rd_addr  output  ADDR_WIDTH  BRAM read address.
REQ-012 rd_data  input  PE_COUNT*DATA_WIDTH  BRAM read data, valid exactly one cycle after rd_en; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 m_valid  output  1  stream data valid.
REQ-014 m_ready  input  1  stream consumer ready.
REQ-015 m_data  output  DATA_WIDTH  one lane per beat.
REQ-016 m_last  output  1  marks final beat of the readback.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on readback completion.

Function
REQ-019 FSM states IDLE, ISSUE, CAPTURE, STREAM, DONE shall be implemented.
REQ-020 IDLE: start=1 -> latch base_addr into address counter, latch min(length, BRAM_DEPTH) into word counter; go to ISSUE, or to DONE if length=0.
REQ-021 ISSUE: rd_en=1, rd_addr=address counter, for exactly one cycle; -> CAPTURE.
REQ-022 CAPTURE: register full rd_data into lane buffer, clear lane index to 0, increment address counter modulo BRAM_DEPTH, decrement word counter; -> STREAM.
REQ-023 STREAM: m_valid=1, m_data=lane buffer[lane index]; on m_valid&&m_ready advance lane index.
REQ-024 STREAM exit on handshake of lane PE_COUNT-1: -> ISSUE if word counter nonzero, else -> DONE.
REQ-025 DONE: done=1 for one cycle; -> IDLE.
REQ-026 m_last=1 only during STREAM, on lane PE_COUNT-1 of the final word (word counter zero).
REQ-027 m_data, m_last shall hold stable while m_valid=1 and m_ready=0; m_valid shall not deassert until handshake.
REQ-028 m_valid=0 in all states other than STREAM; m_ready ignored outside STREAM.
REQ-029 rd_en=0 outside ISSUE; rd_addr holds last driven value when rd_en=0.
REQ-030 Latency: start at cycle T -> rd_en at T+1, first m_valid at T+3; per word minimum PE_COUNT+2 cycles with m_ready held high.
REQ-031 Address wrap: address BRAM_DEPTH-1 followed by 0.
REQ-032 length > BRAM_DEPTH clamped to BRAM_DEPTH; length=0 -> no BRAM read, no beats, done pulse at T+2.
REQ-033 start while busy=1 ignored; base_addr/length changes while busy have no effect.
REQ-034 m_ready asserted before m_valid shall not cause a beat to be skipped or duplicated.

Reset
REQ-035 rstn=0 at a rising edge -> next state IDLE regardless of current state, including mid-STREAM.
REQ-036 Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, counters and lane buffer 0.
REQ-037 After reset release, first start shall behave per REQ-020 with no residual beats from the aborted readback.

Verification
REQ-038 base_addr=5, length=2, m_ready=1, BRAM word k lanes = {k*16+3..k*16+0} -> rd_addr 5 then 6; beats 80,81,82,83,96,97,98,99; m_last on beat 8 only; done one cycle after final beat.
REQ-039 base_addr=1023, length=3 -> rd_addr sequence 1023, 0, 1; 12 beats; m_last on beat 12.
REQ-040 length=0 -> rd_en never asserted, m_valid never asserted, busy high 2 cycles, done at T+2.
REQ-041 length=1, m_ready toggling 1-0-0-1 pseudo-randomly -> exactly 4 beats in lane order 0..3, m_data/m_last stable during stall cycles.
REQ-042 start pulsed again during STREAM with base_addr=100 -> ignored; original sequence completes unaltered; rd_addr never equals 100.
REQ-043 rstn=0 for one cycle after beat 2 of a length=4 readback -> all outputs at REQ-036 values next cycle; new start base_addr=0 length=1 yields exactly 4 beats with m_last on beat 4.
